arm_instr_encoder: RTL and testbench

- Companion block to the control-unit instruction decoder. It takes structured instruction fields (op class, ALU command, cond, S/L flags, registers, immediate) over a valid/ready stream.
- It encodes each one into a 32-bit ARM word in exactly the format the decoder consumes: Op=instr[27:26], Funct=instr[25:20], Rd=instr[15:12].
- It writes the words sequentially into instruction memory through a registered write port.
- It is used to load test programs into imem before and between single-cycle runs.

---
 rtl/arm_instr_encoder.sv | 176 +++++++++++++++++
 tb/tb_arm_instr_encoder.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_instr_encoder.sv
// Packs instruction field bundles into 32-bit ARM words and streams them
// into instruction memory through a registered write port.
module arm_instr_encoder #(
    parameter int ADDR_W = 6,
    parameter int DEPTH  = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        in_op,
    input  logic [1:0]        in_cmd,
    input  logic [3:0]        in_cond,
    input  logic              in_s,
    input  logic              in_imm_sel,
    input  logic [3:0]        in_rn,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rm,
    input  logic [23:0]       in_imm,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   wr_count,
    output logic              busy,
    output logic              full,
    output logic              done,
    output logic              err_illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FULL
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   cnt_q, cnt_d, cnt_inc;
    logic              busy_q, full_q;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic [31:0]       enc;
    logic              legal;
    logic [3:0]        cmd_bits;
    logic              xfer;

    always_comb begin
        cmd_bits = 4'b0100;
        unique case (in_cmd)
            2'b00: cmd_bits = 4'b0100;
            2'b01: cmd_bits = 4'b0010;
            2'b10: cmd_bits = 4'b0000;
            2'b11: cmd_bits = 4'b1100;
        endcase
    end

    always_comb begin
        legal        = 1'b1;
        enc          = '0;
        enc[31:28]   = in_cond;
        enc[27:26]   = in_op;
        enc[19:16]   = in_rn;
        enc[15:12]   = in_rd;
        unique case (in_op)
            2'b00: begin
                enc[25]    = in_imm_sel;
                enc[24:21] = cmd_bits;
                enc[20]    = in_s;
                enc[11:0]  = in_imm_sel ? {4'h0, in_imm[7:0]}
                                        : {8'h00, in_rm};
                legal      = !(in_imm_sel && (|in_imm[23:8]));
            end
            2'b01: begin
                // Register offset sets I; immediate offset clears it.
                enc[25]    = ~in_imm_sel;
                enc[24]    = 1'b1;
                enc[23]    = 1'b1;
                enc[20]    = in_s;
                enc[11:0]  = in_imm_sel ? in_imm[11:0]
                                        : {8'h00, in_rm};
                legal      = !(in_imm_sel && (|in_imm[23:12]));
            end
            2'b10: begin
                enc[25:24] = 2'b10;
                enc[23:0]  = in_imm;
            end
            2'b11: begin
                legal      = 1'b0;
            end
        endcase
    end

    assign in_ready = (state_q == S_RUN);
    assign xfer     = in_valid & in_ready;
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE, S_FULL: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (xfer) begin
                    if (legal) begin
                        we_d    = 1'b1;
                        addr_d  = cnt_q[ADDR_W-1:0];
                        wdata_d = enc;
                        cnt_d   = cnt_inc;
                    end else begin
                        err_d   = 1'b1;
                    end
                    // in_last wins over the depth limit.
                    if (in_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (legal && cnt_inc == DEPTH_C) begin
                        state_d = S_FULL;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d == S_RUN);
            full_q  <= (state_d == S_FULL);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign wr_count    = cnt_q;
    assign busy        = busy_q;
    assign full        = full_q;
    assign done        = done_q;
    assign err_illegal = err_q;

endmodule

// File: tb/tb_arm_instr_encoder.sv
// Scoreboard bench for arm_instr_encoder: a DEPTH=64 and a DEPTH=4
// instance share one stimulus stream; mon_sel picks which one is checked.
module tb_arm_instr_encoder;

    typedef struct packed {
        logic [1:0]  op;
        logic [1:0]  cmd;
        logic [3:0]  cond;
        logic        s;
        logic        isel;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [3:0]  rm;
        logic [23:0] imm;
    } bun_t;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        logic        done;
    } exp_t;

    logic        clk, rst_n, start, in_valid, in_last;
    logic [1:0]  in_op, in_cmd;
    logic [3:0]  in_cond, in_rn, in_rd, in_rm;
    logic        in_s, in_imm_sel;
    logic [23:0] in_imm;

    logic        rdy_a, we_a, busy_a, full_a, done_a, err_a;
    logic [5:0]  addr_a;
    logic [31:0] wd_a;
    logic [6:0]  cnt_a;
    logic        rdy_b, we_b, busy_b, full_b, done_b, err_b;
    logic [5:0]  addr_b;
    logic [31:0] wd_b;
    logic [6:0]  cnt_b;

    logic        mon_sel;
    logic        m_rdy, m_we, m_busy, m_full, m_done, m_err;
    logic [5:0]  m_addr;
    logic [31:0] m_wd;
    logic [6:0]  m_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   w;

    arm_instr_encoder #(.ADDR_W(6), .DEPTH(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(rdy_a), .in_last(in_last),
        .in_op(in_op), .in_cmd(in_cmd), .in_cond(in_cond),
        .in_s(in_s), .in_imm_sel(in_imm_sel), .in_rn(in_rn),
        .in_rd(in_rd), .in_rm(in_rm), .in_imm(in_imm),
        .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wd_a),
        .wr_count(cnt_a), .busy(busy_a), .full(full_a),
        .done(done_a), .err_illegal(err_a)
    );

    arm_instr_encoder #(.ADDR_W(6), .DEPTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(rdy_b), .in_last(in_last),
        .in_op(in_op), .in_cmd(in_cmd), .in_cond(in_cond),
        .in_s(in_s), .in_imm_sel(in_imm_sel), .in_rn(in_rn),
        .in_rd(in_rd), .in_rm(in_rm), .in_imm(in_imm),
        .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wd_b),
        .wr_count(cnt_b), .busy(busy_b), .full(full_b),
        .done(done_b), .err_illegal(err_b)
    );

    assign m_rdy  = mon_sel ? rdy_b  : rdy_a;
    assign m_we   = mon_sel ? we_b   : we_a;
    assign m_addr = mon_sel ? addr_b : addr_a;
    assign m_wd   = mon_sel ? wd_b   : wd_a;
    assign m_cnt  = mon_sel ? cnt_b  : cnt_a;
    assign m_busy = mon_sel ? busy_b : busy_a;
    assign m_full = mon_sel ? full_b : full_a;
    assign m_done = mon_sel ? done_b : done_a;
    assign m_err  = mon_sel ? err_b  : err_a;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference control-unit decode: {PCS, RegW, MemW}.
    function automatic logic [2:0] dec(input logic [31:0] i);
        logic regw, memw, pcs;
        regw = (i[27:26] == 2'b00) || (i[27:26] == 2'b01 && i[20]);
        memw = (i[27:26] == 2'b01) && !i[20];
        pcs  = (i[27:26] == 2'b10) || (i[15:12] == 4'hF && regw);
        return {pcs, regw, memw};
    endfunction

    function automatic bun_t add_imm(input int v);
        return '{2'b00, 2'b00, 4'hE, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 24'(v)};
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input bun_t b, input logic last, input logic exp_we,
                        input logic [5:0] ea, input logic [31:0] ed,
                        output int waits);
        exp_t e;
        if (exp_we) sb.push_back('{ea, ed, last});
        {in_op, in_cmd, in_cond, in_s, in_imm_sel,
         in_rn, in_rd, in_rm, in_imm} = b;
        in_last  = last;
        in_valid = 1'b1;
        waits    = 0;
        while (m_rdy !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got=%b want=1", m_rdy);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        checks++;
        if (m_we !== exp_we) begin
            failures++;
            $display("FAIL write_strobe got=%b want=%b", m_we, exp_we);
        end
        if (m_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got=%h@%0d want=none",
                         m_wd, m_addr);
            end else begin
                e = sb.pop_front();
                if ({m_addr, m_wd, m_done} !== {e.addr, e.data, e.done}) begin
                    failures++;
                    $display("FAIL sb_word got=%0d/%h/%b want=%0d/%h/%b",
                             m_addr, m_wd, m_done, e.addr, e.data, e.done);
                end
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({rdy_a, we_a, addr_a, wd_a, cnt_a, busy_a, full_a, done_a,
             err_a} !== '0) begin
            failures++;
            $display("FAIL reset_state got=%b%b%h%h%h want=0",
                     rdy_a, we_a, addr_a, wd_a, cnt_a);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_a, rdy_a, we_b, busy_b} !== 4'b0) begin
            failures++;
            $display("FAIL idle_hold got=%b%b%b%b want=0000",
                     busy_a, rdy_a, we_b, busy_b);
        end
    endtask

    task automatic test_single_add();
        do_start();
        checks++;
        if ({m_busy, m_rdy, m_cnt} !== {2'b11, 7'd0}) begin
            failures++;
            $display("FAIL start_run got=%b%b/%0d want=11/0",
                     m_busy, m_rdy, m_cnt);
        end
        send(add_imm(5), 1'b1, 1'b1, 6'd0, 32'hE2821005, w);
        checks++;
        if ({m_busy, m_cnt} !== {1'b0, 7'd1}) begin
            failures++;
            $display("FAIL after_last got=%b/%0d want=0/1", m_busy, m_cnt);
        end
        @(negedge clk);
        checks++;
        if ({m_done, m_we} !== 2'b00) begin
            failures++;
            $display("FAIL done_pulse got=%b%b want=00", m_done, m_we);
        end
    endtask

    task automatic test_back_to_back();
        int w2, w3;
        do_start();
        send('{2'b00, 2'b01, 4'hE, 1'b1, 1'b0, 4'd3, 4'd3, 4'd4, 24'd0},
             1'b0, 1'b1, 6'd0, 32'hE0533004, w);
        send('{2'b01, 2'b00, 4'hE, 1'b1, 1'b1, 4'd1, 4'd0, 4'd0, 24'd8},
             1'b0, 1'b1, 6'd1, 32'hE5910008, w2);
        send('{2'b01, 2'b00, 4'hE, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 24'd8},
             1'b1, 1'b1, 6'd2, 32'hE5810008, w3);
        checks++;
        if (w2 + w3 != 0) begin
            failures++;
            $display("FAIL no_bubbles got=%0d want=0 stall cycles", w2 + w3);
        end
    endtask

    task automatic test_cmd_map();
        mon_sel = 1'b1;
        do_start();
        send('{2'b00, 2'b10, 4'hE, 1'b0, 1'b0, 4'd6, 4'd5, 4'd7, 24'd0},
             1'b0, 1'b1, 6'd0, 32'hE0065007, w);
        send('{2'b00, 2'b11, 4'hE, 1'b0, 1'b1, 4'd9, 4'd8, 4'd0, 24'hFF},
             1'b0, 1'b1, 6'd1, 32'hE38980FF, w);
        send('{2'b01, 2'b00, 4'hE, 1'b1, 1'b0, 4'd3, 4'd2, 4'd4, 24'd0},
             1'b0, 1'b1, 6'd2, 32'hE7932004, w);
        send('{2'b01, 2'b00, 4'hE, 1'b0, 1'b1, 4'd1, 4'd0, 4'd0, 24'hFFF},
             1'b1, 1'b1, 6'd3, 32'hE5810FFF, w);
        checks++;
        if ({m_full, m_busy, m_cnt} !== {2'b00, 7'd4}) begin
            failures++;
            $display("FAIL last_at_depth got=%b%b/%0d want=00/4",
                     m_full, m_busy, m_cnt);
        end
        mon_sel = 1'b0;
    endtask

    task automatic test_branch();
        logic [2:0] d;
        do_start();
        send('{2'b10, 2'b00, 4'h0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 24'h10},
             1'b1, 1'b1, 6'd0, 32'h0A000010, w);
        d = dec(m_wd);
        checks++;
        if (d !== 3'b100) begin
            failures++;
            $display("FAIL beq_decode got=%b want=100 (pcs,regw,memw)", d);
        end
    endtask

    task automatic test_illegal();
        do_start();
        send('{2'b11, 2'b00, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0},
             1'b0, 1'b0, 6'd0, 32'h0, w);
        checks++;
        if ({m_err, m_cnt} !== {1'b1, 7'd0}) begin
            failures++;
            $display("FAIL illegal_op got=%b/%0d want=1/0", m_err, m_cnt);
        end
        send('{2'b00, 2'b00, 4'hE, 1'b0, 1'b1, 4'd2, 4'd1, 4'd0, 24'h100},
             1'b0, 1'b0, 6'd0, 32'h0, w);
        send('{2'b01, 2'b00, 4'hE, 1'b1, 1'b1, 4'd1, 4'd0, 4'd0, 24'h1000},
             1'b0, 1'b0, 6'd0, 32'h0, w);
        send(add_imm(5), 1'b0, 1'b1, 6'd0, 32'hE2821005, w);
        checks++;
        if ({m_err, m_cnt} !== {1'b1, 7'd1}) begin
            failures++;
            $display("FAIL err_sticky got=%b/%0d want=1/1", m_err, m_cnt);
        end
        send('{2'b11, 2'b00, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 24'd0},
             1'b1, 1'b0, 6'd0, 32'h0, w);
        checks++;
        if ({m_done, m_busy} !== 2'b10) begin
            failures++;
            $display("FAIL illegal_last got=%b%b want=10", m_done, m_busy);
        end
        do_start();
        checks++;
        if ({m_err, m_busy} !== 2'b01) begin
            failures++;
            $display("FAIL err_clear got=%b%b want=01", m_err, m_busy);
        end
        send(add_imm(7), 1'b1, 1'b1, 6'd0, 32'hE2821007, w);
    endtask

    task automatic test_full();
        mon_sel = 1'b1;
        do_start();
        for (int i = 1; i <= 4; i++)
            send(add_imm(i), 1'b0, 1'b1, 6'(i - 1), 32'hE2821000 | i, w);
        checks++;
        if ({m_full, m_rdy, m_busy, m_cnt} !== {3'b100, 7'd4}) begin
            failures++;
            $display("FAIL full_state got=%b%b%b/%0d want=100/4",
                     m_full, m_rdy, m_busy, m_cnt);
        end
        {in_op, in_cmd, in_cond, in_s, in_imm_sel,
         in_rn, in_rd, in_rm, in_imm} = add_imm(5);
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({m_we, m_full, m_cnt} !== {2'b01, 7'd4}) begin
            failures++;
            $display("FAIL full_hold got=%b%b/%0d want=01/4",
                     m_we, m_full, m_cnt);
        end
        do_start();
        checks++;
        if ({m_busy, m_full, m_rdy, m_cnt} !== {3'b101, 7'd0}) begin
            failures++;
            $display("FAIL full_restart got=%b%b%b/%0d want=101/0",
                     m_busy, m_full, m_rdy, m_cnt);
        end
        send(add_imm(5), 1'b0, 1'b1, 6'd0, 32'hE2821005, w);
        mon_sel = 1'b0;
    endtask

    task automatic test_midreset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        send(add_imm(9), 1'b0, 1'b1, 6'd0, 32'hE2821009, w);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({we_a, busy_a, rdy_a, cnt_a} !== '0) begin
            failures++;
            $display("FAIL async_reset got=%b%b%b/%0d want=000/0",
                     we_a, busy_a, rdy_a, cnt_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_op = '0; in_cmd = '0; in_cond = '0; in_s = 1'b0;
        in_imm_sel = 1'b0; in_rn = '0; in_rd = '0; in_rm = '0;
        in_imm = '0; mon_sel = 1'b0;
        test_reset();
        test_single_add();
        test_back_to_back();
        test_cmd_map();
        test_branch();
        test_illegal();
        test_full();
        test_midreset();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got=%0d want=0 pending", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
